// File: rtl/imem_responder_pkg.sv
// Shared constants and helpers for the instruction-memory responder.
package imem_responder_pkg;

  localparam int          INST_WIDTH      = 32;
  localparam int          INST_ADDR_WIDTH = 32;
  localparam logic [31:0] INST_NOP        = 32'h0000_0013;

  // Active-low reset levels
  localparam logic RST   = 1'b0;
  localparam logic UNRST = 1'b1;

  // Merge the incoming byte into the partially filled word at the given lane.
  // Lanes above the current one read as zero, so a short final word pads cleanly.
  function automatic logic [31:0] assemble_word(input logic [1:0]  lane,
                                                input logic [23:0] lo,
                                                input logic [7:0]  b);
    logic [31:0] w;
    case (lane)
      2'd0:    w = {24'h0, b};
      2'd1:    w = {16'h0, b, lo[7:0]};
      2'd2:    w = {8'h0, b, lo[15:0]};
      default: w = {b, lo};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_responder_loader.sv
// imem_loader: byte-serial image loader. Owns the LOAD/RUN FSM, lane counter,
// word buffer, write pointer and sticky overflow flag, and drives the memory
// write port of imem_responder.
module imem_loader
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [7:0]            ld_data_i,
  input  logic                  ld_last_i,
  input  logic                  reload_i,
  output logic                  boot_done_o,
  output logic                  ovf_o,
  output logic                  we_o,
  output logic [DEPTH_LOG2-1:0] waddr_o,
  output logic [31:0]           wdata_o
);

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

  localparam logic [DEPTH_LOG2:0] WPTR_ONE = (DEPTH_LOG2+1)'(1);

  imem_state_e           state_q;
  logic [1:0]            lane_q;
  logic [23:0]           buf_q;
  logic [DEPTH_LOG2:0]   wptr_q;
  logic                  ovf_q;
  logic                  ready_q;
  logic                  boot_q;

  logic                  accept;
  logic                  wr_evt;
  logic                  wptr_full;

  // Accept/write qualification; wptr MSB set means the array is already full
  always_comb begin
    accept    = ld_valid_i && ready_q && (state_q == IMEM_LOAD);
    wr_evt    = accept && ((lane_q == 2'd3) || ld_last_i);
    wptr_full = wptr_q[DEPTH_LOG2];
  end

  assign we_o        = wr_evt && !wptr_full;
  assign waddr_o     = wptr_q[DEPTH_LOG2-1:0];
  assign wdata_o     = assemble_word(lane_q, buf_q, ld_data_i);
  assign ld_ready_o  = ready_q;
  assign boot_done_o = boot_q;
  assign ovf_o       = ovf_q;

  // LOAD/RUN FSM with byte assembly, pointer saturation and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST) begin
      state_q <= IMEM_LOAD;
      lane_q  <= 2'd0;
      buf_q   <= 24'h0;
      wptr_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      boot_q  <= 1'b0;
    end else begin
      case (state_q)
        IMEM_LOAD: begin
          if (accept) begin
            if (wr_evt) begin
              lane_q <= 2'd0;
              if (wptr_full) ovf_q  <= 1'b1;
              else           wptr_q <= wptr_q + WPTR_ONE;
            end else begin
              lane_q <= lane_q + 2'd1;
              buf_q[lane_q*8 +: 8] <= ld_data_i;
            end
            // Final byte: the transition wins over any same-cycle reload
            if (ld_last_i) begin
              state_q <= IMEM_RUN;
              ready_q <= 1'b0;
              boot_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (reload_i) begin
            state_q <= IMEM_LOAD;
            lane_q  <= 2'd0;
            buf_q   <= 24'h0;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            boot_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory on the core fetch port. Combinational
// fetch returning NOP until an image has been loaded through the byte loader.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, inst_err_o).
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_ADDR_WIDTH-1:0] inst_addr_i,
  output logic [INST_WIDTH-1:0]      inst_o,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  input  logic [7:0]                 ld_data_i,
  input  logic                       ld_last_i,
  input  logic                       reload_i,
  output logic                       boot_done_o,
  output logic                       ovf_o,
  output logic                       inst_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata;

  logic [31:0]           mem_q [0:DEPTH-1];
`ifdef IMEM_PARITY_EN
  logic                  par_q [0:DEPTH-1];
`endif

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  in_range;
  logic                  aligned;
  logic                  fetch_ok;

  imem_loader #(.DEPTH_LOG2(DEPTH_LOG2)) u_loader (
    .clk         (clk),
    .rst         (rst),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_data_i   (ld_data_i),
    .ld_last_i   (ld_last_i),
    .reload_i    (reload_i),
    .boot_done_o (boot_done_o),
    .ovf_o       (ovf_o),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata)
  );

  // Memory array write; contents survive reset and reload
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
`ifdef IMEM_PARITY_EN
      par_q[waddr] <= ^wdata;
`endif
    end
  end

  assign rd_idx   = inst_addr_i[DEPTH_LOG2+1:2];
  assign in_range = (inst_addr_i[INST_ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign aligned  = (inst_addr_i[1:0] == 2'b00);
  assign fetch_ok = boot_done_o && in_range && aligned;

  // Zero-latency fetch; anything not a valid RUN fetch returns NOP
  always_comb begin
    inst_o     = INST_NOP;
    inst_err_o = 1'b0;
    if (fetch_ok) begin
`ifdef IMEM_PARITY_EN
      if (^{mem_q[rd_idx], par_q[rd_idx]}) inst_err_o = 1'b1;
      else                                 inst_o     = mem_q[rd_idx];
`else
      inst_o = mem_q[rd_idx];
`endif
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (built with DEPTH_LOG2 = 2).
module tb_imem_responder;

  localparam int          DL2   = 2;
  localparam int          WORDS = 1 << DL2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        reload_i;
  logic        boot_done_o;
  logic        ovf_o;
  logic        inst_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  bit          ref_known [WORDS];
  bit          ref_run;
  bit          ref_ovf;
  logic [7:0]  img [$];

  imem_responder #(.DEPTH_LOG2(DL2)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_data_i   (ld_data_i),
    .ld_last_i   (ld_last_i),
    .reload_i    (reload_i),
    .boot_done_o (boot_done_o),
    .ovf_o       (ovf_o),
    .inst_err_o  (inst_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: the image becomes ceil(n/4) zero-padded little-endian words; words
  // past the array are lost and flag overflow.
  function automatic void model_commit();
    int nw = (img.size() + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < img.size()) w[8*j +: 8] = img[4*k + j];
      if (k < WORDS) begin
        ref_mem[k]   = w;
        ref_known[k] = 1'b1;
      end
    end
    ref_ovf = (nw > WORDS);
    ref_run = 1'b1;
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    if (!ref_run || a[1:0] != 2'b00 || a >= 32'(4*WORDS)) return NOP;
    return ref_mem[a >> 2];
  endfunction

  // Called at a falling edge; presents one byte, returns at the next falling edge
  task automatic send_byte(input logic [7:0] b, input logic last, input logic rl);
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    ld_last_i  = last;
    reload_i   = rl;
    @(negedge clk);
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    reload_i   = 1'b0;
  endtask

  // Stream img[] with optional idle gaps and ignored reload pulses
  task automatic load_image(input bit gaps, input bit reload_on_last);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        reload_i = $urandom_range(0, 1);
        @(negedge clk);
        reload_i = 1'b0;
      end
      if (i == img.size() - 1) begin
        check("boot_before_last", {31'h0, boot_done_o}, 32'h0);
        send_byte(img[i], 1'b1, reload_on_last);
      end else begin
        send_byte(img[i], 1'b0, 1'b0);
      end
    end
    model_commit();
    check("boot_after_last", {31'h0, boot_done_o}, 32'h1);
    check("ready_after_last", {31'h0, ld_ready_o}, 32'h0);
    check("ovf_after_load", {31'h0, ovf_o}, {31'h0, ref_ovf});
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp, input logic exp_err);
    inst_addr_i = a;
    #1;
    check(tag, inst_o, exp);
    check({tag, "_err"}, {31'h0, inst_err_o}, {31'h0, exp_err});
    @(negedge clk);
  endtask

  task automatic do_reload();
    reload_i = 1'b1;
    @(negedge clk);
    reload_i = 1'b0;
    ref_run = 1'b0;
    ref_ovf = 1'b0;
    check("reload_boot", {31'h0, boot_done_o}, 32'h0);
    check("reload_ovf", {31'h0, ovf_o}, 32'h0);
    check("reload_ready", {31'h0, ld_ready_o}, 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    inst_addr_i = 32'h0;
    ld_valid_i = 1'b0;
    ld_data_i = 8'h0;
    ld_last_i = 1'b0;
    reload_i = 1'b0;
    ref_run = 1'b0;
    ref_ovf = 1'b0;
    for (int k = 0; k < WORDS; k++) ref_known[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // NOP before boot
    check("rst_ready", {31'h0, ld_ready_o}, 32'h1);
    check("rst_boot", {31'h0, boot_done_o}, 32'h0);
    check("rst_ovf", {31'h0, ovf_o}, 32'h0);
    fetch("prebooot_f0", 32'h0, NOP, 1'b0);

    // Two-word load
    img = '{8'h13, 8'h0D, 8'h00, 8'h00, 8'h93, 8'h0D, 8'h00, 8'h00};
    load_image(1'b0, 1'b0);
    fetch("two_f0", 32'h0, 32'h0000_0d13, 1'b0);
    fetch("two_f4", 32'h4, 32'h0000_0d93, 1'b0);
    fetch("two_f2", 32'h2, NOP, 1'b0);

    // Partial last word
    do_reload();
    img = '{8'h13, 8'h0D, 8'h00, 8'h00, 8'hAB};
    load_image(1'b0, 1'b0);
    fetch("part_f4", 32'h4, 32'h0000_00AB, 1'b0);
    fetch("part_f0", 32'h0, 32'h0000_0d13, 1'b0);

    // Reset mid-load aborts the partial word
    do_reload();
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    fetch("midload_nop", 32'h0, NOP, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_ready", {31'h0, ld_ready_o}, 32'h1);
    check("midrst_boot", {31'h0, boot_done_o}, 32'h0);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_image(1'b0, 1'b0);
    fetch("midrst_f0", 32'h0, 32'hDDCC_BBAA, 1'b0);

    // Overflow: 20 bytes into a 4-word array
    do_reload();
    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'h11);
    load_image(1'b0, 1'b0);
    check("ovf_set", {31'h0, ovf_o}, 32'h1);
    for (int a = 0; a < 16; a += 4) fetch("ovf_word", 32'(a), 32'h1111_1111, 1'b0);
    fetch("ovf_f10", 32'h10, NOP, 1'b0);
    do_reload();

    // Randomized images, gaps, ignored reloads and fetches against the model
    for (int r = 0; r < 10; r++) begin
      int n = $urandom_range(1, 24);
      if (ref_run) do_reload();
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      load_image(1'b1, r[0]);
      for (int f = 0; f < 8; f++) begin
        logic [31:0] a;
        case ($urandom_range(0, 2))
          0: a = 32'($urandom_range(0, WORDS-1)) << 2;
          1: a = (32'($urandom_range(0, WORDS-1)) << 2) | 32'($urandom_range(1, 3));
          default: a = 32'($urandom) | 32'h100;
        endcase
        if (a[1:0] != 2'b00 || a >= 32'(4*WORDS) || ref_known[a >> 2])
          fetch("rand_fetch", a, model_fetch(a), 1'b0);
      end
    end

`ifdef IMEM_PARITY_EN
    // Parity fault on a stored word
    do_reload();
    img = '{8'h13, 8'h0D, 8'h00, 8'h00, 8'h93, 8'h0D, 8'h00, 8'h00};
    load_image(1'b0, 1'b0);
    dut.mem_q[1] = dut.mem_q[1] ^ 32'h1;
    fetch("par_f4", 32'h4, NOP, 1'b1);
    fetch("par_f0", 32'h0, 32'h0000_0d13, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
